// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer: owns selection of the 7-segment display source.
// Synchronises and debounces the power and animation switches, resolves
// them to a target mode and sequences mode changes through a timed blank.
module display_mode_sequencer #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int BLANK_TICKS    = 50,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sw_power,
    input  logic [2:0] sw_anim,
    output logic [2:0] mode,
    output logic       en_name,
    output logic       en_a1,
    output logic       en_a2,
    output logic       en_a3,
    output logic       en_err,
    output logic       blank,
    output logic       mode_changed
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_NAME  = 3'd1,
        ST_A1    = 3'd2,
        ST_A2    = 3'd3,
        ST_A3    = 3'd4,
        ST_ERR   = 3'd5,
        ST_BLANK = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LIMIT   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // Bit 0 is power, bits 3:1 are the animation switches.
    logic [3:0]       raw_sw;
    logic [3:0]       sync_meta;
    logic [3:0]       sync_sw;
    logic [3:0]       stable_sw;
    logic [CNT_W-1:0] deb_cnt [4];
    logic [CNT_W-1:0] deb_sat [4];

    state_t           state;
    state_t           state_next;
    state_t           target;
    state_t           last_shown;
    state_t           last_next;
    logic [CNT_W-1:0] blank_cnt;
    logic [CNT_W-1:0] blank_cnt_next;
    logic             changed_next;
    logic [1:0]       anim_count;

    assign raw_sw = {sw_anim, sw_power};
    assign mode   = state;

    // Two-flop synchroniser for every raw switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_sw   <= '0;
        end else begin
            sync_meta <= raw_sw;
            sync_sw   <= sync_meta;
        end
    end

    // Saturating increment of each debounce counter so it can never wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_sat[i] = (deb_cnt[i] == CNT_MAX) ? deb_cnt[i] : deb_cnt[i] + 1'b1;
        end
    end

    // Debounce: the stable value follows the synchronised value only after it has disagreed for DEBOUNCE_TICKS ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_sw <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_sw[i] == stable_sw[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    if (deb_sat[i] >= DEB_LIMIT) begin
                        stable_sw[i] <= sync_sw[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_sat[i];
                    end
                end
            end
        end
    end

    // Priority decode of the debounced switches into the mode we want to show.
    always_comb begin
        anim_count = 2'(stable_sw[1]) + 2'(stable_sw[2]) + 2'(stable_sw[3]);
        target     = ST_NAME;
        if (!stable_sw[0]) begin
            target = ST_OFF;
        end else if (anim_count >= 2'd2) begin
            target = ST_ERR;
        end else if (stable_sw[3]) begin
            target = ST_A3;
        end else if (stable_sw[2]) begin
            target = ST_A2;
        end else if (stable_sw[1]) begin
            target = ST_A1;
        end
    end

    // Next-state logic: power-off wins everywhere, other changes pass through BLANK.
    always_comb begin
        state_next     = state;
        blank_cnt_next = blank_cnt;
        last_next      = last_shown;
        changed_next   = 1'b0;
        if (target == ST_OFF) begin
            state_next     = ST_OFF;
            blank_cnt_next = '0;
            last_next      = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    state_next     = ST_BLANK;
                    blank_cnt_next = '0;
                end
                ST_BLANK: begin
                    if (blank_cnt >= BLANK_LIMIT) begin
                        state_next     = target;
                        blank_cnt_next = '0;
                        last_next      = target;
                        changed_next   = (target != last_shown);
                    end else if (tick) begin
                        blank_cnt_next = blank_cnt + 1'b1;
                    end
                end
                default: begin
                    if (target != state) begin
                        state_next     = ST_BLANK;
                        blank_cnt_next = '0;
                    end
                end
            endcase
        end
    end

    // State register plus registered output decode aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_OFF;
            blank_cnt    <= '0;
            last_shown   <= ST_OFF;
            en_name      <= 1'b0;
            en_a1        <= 1'b0;
            en_a2        <= 1'b0;
            en_a3        <= 1'b0;
            en_err       <= 1'b0;
            blank        <= 1'b1;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_next;
            blank_cnt    <= blank_cnt_next;
            last_shown   <= last_next;
            en_name      <= (state_next == ST_NAME);
            en_a1        <= (state_next == ST_A1);
            en_a2        <= (state_next == ST_A2);
            en_a3        <= (state_next == ST_A3);
            en_err       <= (state_next == ST_ERR);
            blank        <= (state_next == ST_OFF) || (state_next == ST_BLANK);
            mode_changed <= changed_next;
        end
    end

endmodule
